// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers one input vector, bursts it to the linear cells,
// captures their results and drains them serially. ReLU on drain: LAYER_RELU_EN.
module layer_sequencer #(
  parameter int DATA_WIDTH    = 24,
  parameter int INPUT_LENGTH  = 784,
  parameter int NUM_NEURONS   = 10,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  input  logic [DATA_WIDTH-1:0]             s_data,
  output logic                              s_ready,
  output logic                              cell_start,
  output logic [DATA_WIDTH-1:0]             cell_din,
  input  logic                              cell_done,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] cell_dout,
  output logic                              m_valid,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [$clog2(NUM_NEURONS)-1:0]    m_index,
  output logic                              m_last,
  input  logic                              m_ready,
  output logic                              busy
);
  localparam int AW  = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1;
  localparam int CW  = $clog2(INPUT_LENGTH + 1);
  localparam int IW  = $clog2(NUM_NEURONS);
  localparam int DLW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

  localparam logic [CW-1:0]  LAST_WR  = CW'(INPUT_LENGTH - 1);
  localparam logic [CW-1:0]  LAST_K   = CW'(INPUT_LENGTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_NEURONS - 1);
  localparam logic [DLW-1:0] LAST_DLY =
    DLW'((CAPTURE_DELAY > 0) ? CAPTURE_DELAY - 1 : 0);

  typedef enum logic [2:0] {
    LOAD, STREAM, WAIT, SETTLE, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         st_cnt;
  logic [DLW-1:0]        dly;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] mem [INPUT_LENGTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] bank [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] word;

  logic s_fire, m_fire, rd_en, settle_hit, cap;

  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign rd_en      = (state_q == STREAM) && (st_cnt != LAST_K);
  assign settle_hit = (dly == LAST_DLY);
  assign cap        = (CAPTURE_DELAY == 0)
                    ? (state_q == WAIT && cell_done)
                    : (state_q == SETTLE && settle_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (s_fire && wr_cnt == LAST_WR) state_d = STREAM;
      STREAM:  if (st_cnt == LAST_K) state_d = WAIT;
      WAIT:    if (cell_done)
                 state_d = (CAPTURE_DELAY == 0) ? DRAIN : SETTLE;
      SETTLE:  if (settle_hit) state_d = DRAIN;
      DRAIN:   if (m_fire && m_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      st_cnt <= '0;
      dly    <= '0;
      rd_idx <= '0;
    end else begin
      if (m_fire && m_last) wr_cnt <= '0;
      else if (s_fire)      wr_cnt <= wr_cnt + 1'b1;
      st_cnt <= rd_en ? st_cnt + 1'b1 : '0;
      dly    <= (state_q == SETTLE) ? dly + 1'b1 : '0;
      if (cap)         rd_idx <= '0;
      else if (m_fire) rd_idx <= m_last ? '0 : rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire) mem[wr_cnt[AW-1:0]] <= s_data;
  end

  // Read register doubles as cell_din; it holds the last sample after the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_q <= '0;
    else if (rd_en) rd_q <= mem[st_cnt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) bank[n] <= '0;
    end else if (cap) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        bank[n] <= cell_dout[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign raw = bank[rd_idx];
`ifdef LAYER_RELU_EN
  assign word = raw[DATA_WIDTH-1] ? '0 : raw;
`else
  assign word = raw;
`endif

  assign s_ready    = (state_q == LOAD);
  assign cell_start = (state_q == STREAM) && (st_cnt == CW'(1));
  assign cell_din   = rd_q;
  assign m_valid    = (state_q == DRAIN);
  assign m_data     = m_valid ? word : '0;
  assign m_index    = rd_idx;
  assign m_last     = m_valid && (rd_idx == LAST_IDX);
  assign busy       = !(state_q == LOAD && wr_cnt == '0);

endmodule
